// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin front end for one shared sign-magnitude
// multiplier. Requests are registered into an operand stage (S1) that drives
// the external combinational multiplier, and the product is captured into a
// result stage (S2) tagged with the index of the requester that issued it.
module mult_rr_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ID_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic [DATA_W-1:0]         mul_a,
   output logic [DATA_W-1:0]         mul_b,
   input  logic [DATA_W-1:0]         mul_c,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      busy
);

   // S1: operand stage feeding the shared multiplier
   logic              s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]   s1_id_q,    s1_id_d;
   logic [DATA_W-1:0] mul_a_q,    mul_a_d;
   logic [DATA_W-1:0] mul_b_q,    mul_b_d;

   // S2: result stage presented downstream
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [ID_W-1:0]   rsp_id_q,   rsp_id_d;

   // Round-robin pointer: first index scanned on the next arbitration
   logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;

   logic              adv2;
   logic              accept;
   logic              gnt_found;
   logic [ID_W-1:0]   gnt_idx;
   logic              hs;

   // Pipeline flow control and rotating-priority grant selection
   always_comb begin
      int unsigned idx;
      logic [ID_W-1:0] idx_w;
      idx       = 0;
      idx_w     = '0;
      adv2      = s1_valid_q & (~s2_valid_q | rsp_ready);
      accept    = ~s1_valid_q | adv2;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx   = (32'(rr_ptr_q) + i) % NUM_REQ;
         idx_w = ID_W'(idx);
         if (!gnt_found && req_valid[idx_w]) begin
            gnt_found = 1'b1;
            gnt_idx   = idx_w;
         end
      end
      // rst gates the grant so no request is acknowledged while held in reset
      hs        = gnt_found & accept & ~rst;
      req_ready = '0;
      if (hs) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Next-state for both pipeline stages and the round-robin pointer
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_id_d    = s1_id_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      s2_valid_d = s2_valid_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rr_ptr_d   = rr_ptr_q;

      if (adv2) begin
         rsp_data_d = mul_c;
         rsp_id_d   = s1_id_q;
         s2_valid_d = 1'b1;
         s1_valid_d = 1'b0;
      end else if (s2_valid_q && rsp_ready) begin
         s2_valid_d = 1'b0;
      end

      // a same-cycle handshake refills S1 after it drains into S2
      if (hs) begin
         s1_valid_d = 1'b1;
         s1_id_d    = gnt_idx;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
               mul_a_d = req_a[i*DATA_W +: DATA_W];
               mul_b_d = req_b[i*DATA_W +: DATA_W];
            end
         end
         if (32'(gnt_idx) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx + ID_W'(1);
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         s2_valid_q <= 1'b0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         rr_ptr_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
         s2_valid_q <= s2_valid_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_valid = s2_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler with a Q4.27 sign-magnitude
// multiplier model closing the mul_a/mul_b -> mul_c loop.
module tb_mult_rr_scheduler;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [31:0]  mul_a;
   logic [31:0]  mul_b;
   logic [31:0]  mul_c;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [31:0]  rsp_data;
   logic [1:0]   rsp_id;
   logic         busy;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] exp_data [4];
   int          checks;
   int          failures;
   logic [61:0] prod;

   mult_rr_scheduler #(
      .NUM_REQ(4),
      .DATA_W (32),
      .ID_W   (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .mul_a    (mul_a),
      .mul_b    (mul_b),
      .mul_c    (mul_c),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_id   (rsp_id),
      .busy     (busy)
   );

   // External multiplier: sign xor, magnitude product rescaled by 2^-27
   always_comb begin
      prod  = {31'b0, mul_a[30:0]} * {31'b0, mul_b[30:0]};
      mul_c = {mul_a[31] ^ mul_b[31], prod[57:27]};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: pop the oldest expectation on every accepted response
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected actual id=%0d data=%h expected=none", rsp_id, rsp_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
            chk("rsp_data", rsp_data, mon_e.data);
         end
      end
   end

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      exp_data[i]       = p;
   endtask

   // One arbitration cycle: check the expected grant, optionally queue its
   // result, then drop granted one-shot requesters after the edge
   task automatic step(input logic [3:0] exp_rdy, input logic [3:0] persist,
                       input bit push, input string name);
      logic [3:0] hs;
      @(negedge clk);
      chk(name, 32'(req_ready), 32'(exp_rdy));
      hs = req_valid & req_ready;
      if (push) begin
         for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) exp_q.push_back('{id: 2'(i), data: exp_data[i]});
         end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(hs & ~persist);
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
      @(posedge clk);
      #1;
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] e;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      for (int i = 0; i < 4; i++) exp_data[i] = '0;

      // reset state, with every requester asking
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_mul_b", mul_b, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = '0;

      // single request from requester 2: 2.0 * -1.5 = -3.0
      set_lane(2, 32'h1000_0000, 32'h8C00_0000, 32'h9800_0000);
      rsp_ready = 1'b1;
      req_valid = 4'b0100;
      step(4'b0100, 4'b0000, 1'b1, "t1_grant");
      @(negedge clk);
      chk("t1_n1_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t1_n1_busy", 32'(busy), 32'd1);
      chk("t1_n1_mul_a", mul_a, 32'h1000_0000);
      chk("t1_n1_mul_b", mul_b, 32'h8C00_0000);
      @(negedge clk);
      chk("t1_n2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1_n2_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_n3_busy", 32'(busy), 32'd0);
      chk("t1_n3_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;

      // all four requesters continuously valid: 1.0 * 1.0
      reset_dut();
      for (int i = 0; i < 4; i++) set_lane(i, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         e = 4'b0001 << (k % 4);
         step(e, 4'hF, 1'b1, "t2_rr_grant");
      end
      req_valid = '0;
      wait_drain("t2_drain");

      // backpressure with three requesters, including a negative-zero product
      set_lane(0, 32'h0800_0000, 32'h1000_0000, 32'h1000_0000);
      set_lane(1, 32'h0800_0000, 32'h8800_0000, 32'h8800_0000);
      set_lane(2, 32'h8000_0000, 32'h0400_0000, 32'h8000_0000);
      rsp_ready = 1'b0;
      req_valid = 4'b0111;
      step(4'b0001, 4'b0000, 1'b1, "t3_c0");
      step(4'b0010, 4'b0000, 1'b1, "t3_c1");
      for (int c = 2; c < 5; c++) begin
         step(4'b0000, 4'b0000, 1'b1, "t3_stall_ready");
         chk("t3_stall_valid", 32'(rsp_valid), 32'd1);
         chk("t3_stall_data", rsp_data, 32'h1000_0000);
         chk("t3_stall_id", 32'(rsp_id), 32'd0);
      end
      rsp_ready = 1'b1;
      step(4'b0100, 4'b0000, 1'b1, "t3_resume");
      wait_drain("t3_drain");

      // fairness: requester 0 always valid, requester 3 joins at cycle 10
      reset_dut();
      set_lane(0, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
      set_lane(3, 32'h1800_0000, 32'h1000_0000, 32'h3000_0000);
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      for (int c = 0; c < 10; c++) step(4'b0001, 4'b0001, 1'b1, "t4_r0");
      req_valid[3] = 1'b1;
      step(4'b1000, 4'b0001, 1'b1, "t4_r3");
      chk("t4_rr_wrap", 32'(dut.rr_ptr_q), 32'd0);
      step(4'b0001, 4'b0001, 1'b1, "t4_after");
      req_valid = '0;
      wait_drain("t4_drain");

      // reset while both stages hold discarded work
      set_lane(1, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
      set_lane(2, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000);
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      step(4'b0010, 4'b0000, 1'b0, "t5_pre_a");
      step(4'b0100, 4'b0000, 1'b0, "t5_pre_b");
      chk("t5_full_busy", 32'(busy), 32'd1);
      chk("t5_full_valid", 32'(rsp_valid), 32'd1);
      set_lane(1, 32'h1000_0000, 32'h1000_0000, 32'h2000_0000);
      set_lane(3, 32'h0800_0000, 32'h9800_0000, 32'h9800_0000);
      req_valid = 4'b1010;
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_valid", 32'(rsp_valid), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      chk("t5_async_ready", 32'(req_ready), 32'd0);
      chk("t5_async_data", rsp_data, 32'd0);
      chk("t5_async_mul_a", mul_a, 32'd0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      rst       = 1'b0;
      #1;
      chk("t5_no_stale", 32'(rsp_valid), 32'd0);
      step(4'b0010, 4'b0000, 1'b1, "t5_first");
      step(4'b1000, 4'b0000, 1'b1, "t5_second");
      wait_drain("t5_drain");

      // idle: nothing requested for 20 cycles
      req_valid = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("t6_ready", 32'(req_ready), 32'd0);
         chk("t6_valid", 32'(rsp_valid), 32'd0);
         chk("t6_busy", 32'(busy), 32'd0);
      end
      chk("t6_rr_hold", 32'(dut.rr_ptr_q), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
